apb_stream_regs: RTL and testbench

- Parametrised APB slave register bank, successor to the Ascon wrapper register file.
- Provides: control/status, interrupt, generic config words, read-only words, NumWr write-streams (valid/ready push) and NumRd read-streams (valid/ready pop), each BlkWidth bits wide.
- Unlike the fixed-map predecessor, it applies real back-pressure: APB wait states while a stream is busy, timeout-to-error, and a self-clearing start pulse.
- Sits between the APB interconnect and the crypto core / its FIFOs.

---
 rtl/apb_stream_regs.sv | 241 ++++++++++++++++++++++++
 tb/tb_apb_stream_regs.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_stream_regs.sv
// APB slave register bank: control/status, interrupts, config and read-only
// words, plus block-wide write streams (push) and read streams (pop) that
// back-pressure the bus with wait states and time out into PSLVERR.
//
// Handshake rules:
//   APB: a transfer completes in the first PSEL&&PENABLE cycle with PREADY=1.
//   Stream: wr_valid_o/rd_valid_i mark a block; it transfers on a cycle where
//   valid&&ready. wr_valid_o holds with stable data until wr_ready_i.
//   rd_ready_o is a single-cycle pop of the head block.
module apb_stream_regs #(
  parameter int APB_AW        = 10,
  parameter int APB_DW        = 32,
  parameter int BlkWidth      = 64,
  parameter int NumWr         = 2,
  parameter int NumRd         = 1,
  parameter int CfgWords      = 8,
  parameter int RoWords       = 4,
  parameter int TimeoutCycles = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [APB_AW-1:0]            PADDR,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [APB_DW-1:0]            PWDATA,
  output logic [APB_DW-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic                         start_o,
  output logic [APB_DW-2:0]            ctrl_o,
  output logic [CfgWords*APB_DW-1:0]   cfg_o,
  input  logic [RoWords*APB_DW-1:0]    ro_i,
  input  logic                         ready_i,
  input  logic                         tag_valid_i,
  output logic [NumWr*BlkWidth-1:0]    wr_data_o,
  output logic [NumWr-1:0]             wr_valid_o,
  input  logic [NumWr-1:0]             wr_ready_i,
  input  logic [NumRd*BlkWidth-1:0]    rd_data_i,
  input  logic [NumRd-1:0]             rd_valid_i,
  output logic [NumRd-1:0]             rd_ready_o,
  output logic                         irq_o
);

  localparam int W            = BlkWidth / APB_DW;
  localparam int BYTE_SH      = $clog2(APB_DW / 8);
  localparam int IDX_CTRL     = 0;
  localparam int IDX_STATUS   = 1;
  localparam int IDX_IRQ_EN   = 2;
  localparam int IDX_IRQ_STAT = 3;
  localparam int CFG_BASE     = 4;
  localparam int RO_BASE      = CFG_BASE + CfgWords;
  localparam int WR_BASE      = RO_BASE + RoWords;
  localparam int RD_BASE      = WR_BASE + NumWr * W;
  localparam int REG_NO       = RD_BASE + NumRd * W;
  localparam int CNT_W        = $clog2(TimeoutCycles + 1);

  // Storage
  logic [APB_DW-2:0] ctrl_q;
  logic [2:0]        irq_en;
  logic [2:0]        irq_stat;
  logic              ready_d;
  logic              tag_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic [APB_DW-1:0] cfg_q  [CfgWords];
  logic [APB_DW-1:0] wr_mem [NumWr][W];
  logic [W-1:0]      wr_mask [NumWr];
  logic [W-1:0]      rd_mask [NumRd];

  // Decode / handshake
  int                idx;
  logic              unaligned;
  logic              is_ro;
  logic              is_rd;
  logic              dec_err;
  logic              stall;
  logic [W-1:0]      wr_hit [NumWr];
  logic [W-1:0]      rd_hit [NumRd];
  logic [NumWr-1:0]  wr_any;
  logic [NumRd-1:0]  rd_any;
  logic [NumWr-1:0]  wr_push;
  logic              access;
  logic              timeout_hit;
  logic              done;
  logic              err;
  logic              wr_en;
  logic              rd_en;
  logic [APB_DW-1:0] rdata;
  logic [2:0]        irq_set;
  logic [2:0]        irq_clr;

  // Address decode, illegal-access detection and stream stall conditions
  always_comb begin
    idx       = int'(PADDR >> BYTE_SH);
    unaligned = (PADDR[BYTE_SH-1:0] != '0);
    is_ro     = (idx == IDX_STATUS) || ((idx >= RO_BASE) && (idx < WR_BASE));
    is_rd     = (idx >= RD_BASE) && (idx < REG_NO);
    dec_err   = unaligned || (idx >= REG_NO) || (PWRITE && (is_ro || is_rd));
    for (int s = 0; s < NumWr; s++) begin
      wr_hit[s] = '0;
      for (int w = 0; w < W; w++) wr_hit[s][w] = (idx == WR_BASE + s * W + w);
      wr_any[s] = |wr_hit[s];
    end
    for (int r = 0; r < NumRd; r++) begin
      rd_hit[r] = '0;
      for (int w = 0; w < W; w++) rd_hit[r][w] = (idx == RD_BASE + r * W + w);
      rd_any[r] = |rd_hit[r];
    end
    stall = 1'b0;
    for (int s = 0; s < NumWr; s++)
      if (PWRITE && wr_any[s] && wr_valid_o[s]) stall = 1'b1;
    for (int r = 0; r < NumRd; r++)
      if (!PWRITE && rd_any[r] && !rd_valid_i[r]) stall = 1'b1;
    if (dec_err) stall = 1'b0;
  end

  assign access      = PSEL && PENABLE;
  assign timeout_hit = stall && (wait_cnt == CNT_W'(TimeoutCycles));
  assign done        = access && (!stall || timeout_hit);
  assign err         = done && (dec_err || timeout_hit);
  assign wr_en       = done && PWRITE && !err;
  assign rd_en       = done && !PWRITE && !err;

  assign PREADY  = done;
  assign PSLVERR = err;
  assign PRDATA  = rd_en ? rdata : '0;

  // Read data mux over the whole register map
  always_comb begin
    rdata = '0;
    if (idx == IDX_CTRL)     rdata = {ctrl_q, 1'b0};
    if (idx == IDX_STATUS)   rdata = APB_DW'({rd_valid_i, wr_valid_o, tag_valid_i, ready_i});
    if (idx == IDX_IRQ_EN)   rdata = APB_DW'(irq_en);
    if (idx == IDX_IRQ_STAT) rdata = APB_DW'(irq_stat);
    for (int k = 0; k < CfgWords; k++)
      if (idx == CFG_BASE + k) rdata = cfg_q[k];
    for (int k = 0; k < RoWords; k++)
      if (idx == RO_BASE + k) rdata = ro_i[(RoWords-k)*APB_DW-1 -: APB_DW];
    for (int s = 0; s < NumWr; s++)
      for (int w = 0; w < W; w++)
        if (wr_hit[s][w]) rdata = wr_mem[s][w];
    for (int r = 0; r < NumRd; r++)
      for (int w = 0; w < W; w++)
        if (rd_hit[r][w]) rdata = rd_data_i[r*BlkWidth + (W-w)*APB_DW - 1 -: APB_DW];
  end

  // Block completion: last word accessed and every word of the block seen
  always_comb begin
    for (int s = 0; s < NumWr; s++)
      wr_push[s] = wr_en && wr_hit[s][W-1] && (&(wr_mask[s] | wr_hit[s]));
    for (int r = 0; r < NumRd; r++)
      rd_ready_o[r] = rd_en && rd_hit[r][W-1] && (&(rd_mask[r] | rd_hit[r]));
  end

  // Interrupt events and write-1-to-clear; setting wins over clearing
  always_comb begin
    irq_set = {err, tag_valid_i & ~tag_d, ready_i & ~ready_d};
    irq_clr = (wr_en && (idx == IDX_IRQ_STAT)) ? PWDATA[2:0] : 3'b000;
  end

  // Control, interrupt state and the wait-state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      start_o  <= 1'b0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq_o    <= 1'b0;
      ready_d  <= 1'b0;
      tag_d    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      start_o <= wr_en && (idx == IDX_CTRL) && PWDATA[0];
      if (wr_en && (idx == IDX_CTRL))   ctrl_q <= PWDATA[APB_DW-1:1];
      if (wr_en && (idx == IDX_IRQ_EN)) irq_en <= PWDATA[2:0];
      irq_stat <= (irq_stat & ~irq_clr) | irq_set;
      irq_o    <= |(irq_stat & irq_en);
      ready_d  <= ready_i;
      tag_d    <= tag_valid_i;
      wait_cnt <= (access && stall && !timeout_hit) ? wait_cnt + CNT_W'(1) : '0;
    end
  end

  // Config words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CfgWords; k++) cfg_q[k] <= '0;
    end else begin
      for (int k = 0; k < CfgWords; k++)
        if (wr_en && (idx == CFG_BASE + k)) cfg_q[k] <= PWDATA;
    end
  end

  // Write streams: word capture, written mask and registered valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_o <= '0;
      for (int s = 0; s < NumWr; s++) begin
        wr_mask[s] <= '0;
        for (int w = 0; w < W; w++) wr_mem[s][w] <= '0;
      end
    end else begin
      for (int s = 0; s < NumWr; s++) begin
        for (int w = 0; w < W; w++)
          if (wr_en && wr_hit[s][w]) wr_mem[s][w] <= PWDATA;
        if (wr_push[s]) begin
          wr_mask[s]    <= '0;
          wr_valid_o[s] <= 1'b1;
        end else begin
          if (wr_en && wr_any[s]) wr_mask[s] <= wr_mask[s] | wr_hit[s];
          if (wr_valid_o[s] && wr_ready_i[s]) wr_valid_o[s] <= 1'b0;
        end
      end
    end
  end

  // Read streams: read mask, cleared on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NumRd; r++) rd_mask[r] <= '0;
    end else begin
      for (int r = 0; r < NumRd; r++) begin
        if (rd_ready_o[r])            rd_mask[r] <= '0;
        else if (rd_en && rd_any[r])  rd_mask[r] <= rd_mask[r] | rd_hit[r];
      end
    end
  end

  assign ctrl_o = ctrl_q;

  // Lowest address holds the most significant word
  for (genvar k = 0; k < CfgWords; k++) begin : g_cfg
    assign cfg_o[(CfgWords-k)*APB_DW-1 -: APB_DW] = cfg_q[k];
  end
  for (genvar s = 0; s < NumWr; s++) begin : g_wr
    for (genvar w = 0; w < W; w++) begin : g_word
      assign wr_data_o[s*BlkWidth + (W-w)*APB_DW - 1 -: APB_DW] = wr_mem[s][w];
    end
  end

endmodule

// File: tb/tb_apb_stream_regs.sv
// Self-checking bench for apb_stream_regs with default parameters
// (32-bit APB, 64-bit blocks, 2 write streams, 1 read stream).
module tb_apb_stream_regs;

  localparam int LIMIT = 400;

  // Address map in bytes
  localparam logic [9:0] A_CTRL = 10'd0,  A_STATUS = 10'd4, A_IRQ_EN = 10'd8, A_IRQ_STAT = 10'd12;
  localparam logic [9:0] A_CFG  = 10'd16, A_RO = 10'd48, A_WR = 10'd64, A_RD = 10'd80, A_END = 10'd88;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]   PADDR = '0;
  logic         PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0]  PWDATA = '0;
  logic [31:0]  PRDATA;
  logic         PREADY, PSLVERR, start_o, irq_o;
  logic [30:0]  ctrl_o;
  logic [255:0] cfg_o;
  logic [127:0] ro_i = '0;
  logic         ready_i = 1'b0, tag_valid_i = 1'b0;
  logic [127:0] wr_data_o;
  logic [1:0]   wr_valid_o;
  logic [1:0]   wr_ready_i = 2'b11;
  logic [63:0]  rd_data_i = '0;
  logic [0:0]   rd_valid_i = 1'b0;
  logic [0:0]   rd_ready_o;

  apb_stream_regs dut (
    .clk(clk), .rst_n(rst_n), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .start_o(start_o), .ctrl_o(ctrl_o), .cfg_o(cfg_o),
    .ro_i(ro_i), .ready_i(ready_i), .tag_valid_i(tag_valid_i),
    .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
    .irq_o(irq_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] cfg_m [8];
  logic [31:0] ro_m  [4];
  logic [30:0] ctrl_m = '0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  function automatic logic [31:0] status_model(input logic rdv, input logic [1:0] wrv,
                                               input logic tag, input logic rdy);
    return {27'd0, rdv, wrv, tag, rdy};
  endfunction

  // Driver: one APB transfer, bounded wait, sampled at the falling edge
  task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits,
                          output logic pop);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!PREADY && waits <= LIMIT) begin
      waits++;
      @(negedge clk);
    end
    rdata = PRDATA; err = PSLVERR; pop = rd_ready_o[0];
    if (!PREADY) check("apb_wait_bound", 64'(waits), 64'(LIMIT));
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic reg_write(input logic [9:0] a, input logic [31:0] d, input string tag);
    logic [31:0] r; logic e; int wt; logic p;
    apb_xfer(1'b1, a, d, r, e, wt, p);
    check({tag, "_err"}, 64'(e), 64'd0);
    check({tag, "_waits"}, 64'(wt), 64'd0);
  endtask

  task automatic reg_read(input logic [9:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] r; logic e; int wt; logic p;
    apb_xfer(1'b0, a, 32'd0, r, e, wt, p);
    check(tag, 64'(r), 64'(exp));
    check({tag, "_err"}, 64'(e), 64'd0);
    check({tag, "_waits"}, 64'(wt), 64'd0);
  endtask

  task automatic err_access(input logic wr, input logic [9:0] a, input string tag);
    logic [31:0] r; logic e; int wt; logic p;
    apb_xfer(wr, a, $urandom, r, e, wt, p);
    check({tag, "_slverr"}, 64'(e), 64'd1);
    check({tag, "_rdata"}, 64'(r), 64'd0);
    check({tag, "_waits"}, 64'(wt), 64'd0);
  endtask

  task automatic push_block(input int s, input logic [63:0] blk);
    logic [31:0] r; logic e; int wt; logic p;
    if (s == 0) exp_q0.push_back(blk); else exp_q1.push_back(blk);
    apb_xfer(1'b1, A_WR + 10'(s * 8), blk[63:32], r, e, wt, p);
    check("push_w0_err", 64'(e), 64'd0);
    apb_xfer(1'b1, A_WR + 10'(s * 8 + 4), blk[31:0], r, e, wt, p);
    check("push_w1_err", 64'(e), 64'd0);
  endtask

  // Scoreboard: every accepted block must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid_o[0] && wr_ready_i[0]) begin
        check("push0_pending", 64'(exp_q0.size() != 0), 64'd1);
        if (exp_q0.size() != 0) check("push0_data", wr_data_o[63:0], exp_q0.pop_front());
      end
      if (wr_valid_o[1] && wr_ready_i[1]) begin
        check("push1_pending", 64'(exp_q1.size() != 0), 64'd1);
        if (exp_q1.size() != 0) check("push1_data", wr_data_o[127:64], exp_q1.pop_front());
      end
    end
  end

  logic [31:0]  rdv;
  logic         ev, pv;
  int           wv;
  int           s, k, op;
  logic [31:0]  v;
  logic [63:0]  blk;
  logic [255:0] exp_cfg;
  logic [1:0]   seen;
  logic         exp_pop;
  int           ww;

  initial begin
    for (int i = 0; i < 8; i++) cfg_m[i] = '0;
    for (int i = 0; i < 4; i++) ro_m[i] = $urandom;
    ro_i = {ro_m[0], ro_m[1], ro_m[2], ro_m[3]};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata", 64'(PRDATA), 64'd0);
    check("rst_pslverr", 64'(PSLVERR), 64'd0);
    check("rst_start", 64'(start_o), 64'd0);
    check("rst_wr_valid", 64'(wr_valid_o), 64'd0);
    check("rst_rd_ready", 64'(rd_ready_o), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_cfg_o", 64'(|cfg_o), 64'd0);
    check("rst_ctrl_o", 64'(ctrl_o), 64'd0);
    rst_n = 1'b1;
    reg_read(A_CTRL, 32'd0, "rst_ctrl_rd");
    reg_read(A_STATUS, status_model(1'b0, 2'b00, 1'b0, 1'b0), "rst_status");
    reg_read(A_IRQ_STAT, 32'd0, "rst_irq_stat");

    // Config word 0
    reg_write(A_CFG, 32'hDEADBEEF, "cfg0_wr");
    cfg_m[0] = 32'hDEADBEEF;
    reg_read(A_CFG, 32'hDEADBEEF, "cfg0_rd");
    check("cfg0_out", 64'(cfg_o[255:224]), 64'hDEADBEEF);

    // Random register traffic against the model
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 6);
      k  = $urandom_range(0, 7);
      v  = $urandom;
      case (op)
        0: begin reg_write(A_CFG + 10'(4 * k), v, "rnd_cfg_wr"); cfg_m[k] = v; end
        1: reg_read(A_CFG + 10'(4 * k), cfg_m[k], "rnd_cfg_rd");
        2: reg_read(A_RO + 10'(4 * (k % 4)), ro_m[k % 4], "rnd_ro_rd");
        3: begin
          reg_write(A_CTRL, v, "rnd_ctrl_wr");
          ctrl_m = v[31:1];
          check("rnd_start", 64'(start_o), 64'(v[0]));
        end
        4: reg_read(A_CTRL, {ctrl_m, 1'b0}, "rnd_ctrl_rd");
        5: begin
          reg_write(A_IRQ_EN, v, "rnd_irqen_wr");
          reg_read(A_IRQ_EN, {29'd0, v[2:0]}, "rnd_irqen_rd");
        end
        default: begin
          if (v[0]) err_access(v[1], A_CFG + 10'(4 * k) + 10'($urandom_range(1, 3)), "rnd_unaligned");
          else      err_access(1'b0, A_END + 10'(4 * $urandom_range(0, 10)), "rnd_range");
        end
      endcase
    end
    for (int i = 0; i < 8; i++) exp_cfg[(8-i)*32-1 -: 32] = cfg_m[i];
    check("cfg_o_hi", cfg_o[255:192], exp_cfg[255:192]);
    check("cfg_o_mid_hi", cfg_o[191:128], exp_cfg[191:128]);
    check("cfg_o_mid_lo", cfg_o[127:64], exp_cfg[127:64]);
    check("cfg_o_lo", cfg_o[63:0], exp_cfg[63:0]);
    check("ctrl_o_rnd", 64'(ctrl_o), 64'(ctrl_m));

    // Start pulse
    reg_write(A_CTRL, 32'h5, "ctrl5_wr");
    ctrl_m = 31'd2;
    check("start_hi", 64'(start_o), 64'd1);
    @(posedge clk); #1;
    check("start_lo", 64'(start_o), 64'd0);
    reg_read(A_CTRL, 32'h4, "ctrl5_rd");
    check("ctrl_o_5", 64'(ctrl_o), 64'd2);

    // Illegal accesses
    reg_write(A_IRQ_STAT, 32'h7, "irq_clr_all");
    reg_read(A_IRQ_STAT, 32'd0, "irq_stat_clear");
    reg_write(A_IRQ_EN, 32'h4, "irq_en4");
    err_access(1'b1, A_STATUS, "wr_status");
    err_access(1'b0, 10'h2, "unaligned_rd");
    err_access(1'b0, A_END, "range_rd");
    err_access(1'b1, A_END, "range_wr");
    err_access(1'b1, A_RO, "wr_ro");
    err_access(1'b1, A_RD, "wr_rdstream");
    reg_read(A_CTRL, {ctrl_m, 1'b0}, "ctrl_after_err");
    reg_read(A_RO, ro_m[0], "ro_after_err");
    reg_read(A_IRQ_STAT, 32'h4, "irq_stat_err");
    repeat (2) @(posedge clk); #1;
    check("irq_o_err", 64'(irq_o), 64'd1);
    reg_write(A_IRQ_STAT, 32'h4, "irq_clr4");
    reg_read(A_IRQ_STAT, 32'd0, "irq_stat_cleared");
    repeat (2) @(posedge clk); #1;
    check("irq_o_cleared", 64'(irq_o), 64'd0);

    // Rising-edge interrupts and partial clear
    reg_write(A_IRQ_EN, 32'h3, "irq_en3");
    @(posedge clk); #1; ready_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    reg_read(A_IRQ_STAT, 32'h1, "irq_ready_edge");
    tag_valid_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    reg_read(A_IRQ_STAT, 32'h3, "irq_tag_edge");
    check("irq_o_edges", 64'(irq_o), 64'd1);
    reg_write(A_IRQ_STAT, 32'h1, "irq_clr1");
    reg_read(A_IRQ_STAT, 32'h2, "irq_partial_clr");
    reg_write(A_IRQ_STAT, 32'h7, "irq_clr7");
    reg_read(A_IRQ_STAT, 32'h0, "irq_all_clr");

    // Directed push on stream 0
    wr_ready_i = 2'b11;
    push_block(0, 64'h11111111_22222222);
    check("push_valid_hi", 64'(wr_valid_o[0]), 64'd1);
    check("push_data", wr_data_o[63:0], 64'h11111111_22222222);
    @(posedge clk); #1;
    check("push_valid_lo", 64'(wr_valid_o[0]), 64'd0);

    // Back-pressure timeout on stream 0
    reg_write(A_IRQ_EN, 32'h4, "irq_en4b");
    wr_ready_i[0] = 1'b0;
    blk = {$urandom, $urandom};
    push_block(0, blk);
    apb_xfer(1'b1, A_WR, ~blk[63:32], rdv, ev, wv, pv);
    check("timeout_waits", 64'(wv), 64'd255);
    check("timeout_slverr", 64'(ev), 64'd1);
    reg_read(A_WR, blk[63:32], "stalled_stream_rd");
    reg_read(A_STATUS, status_model(1'b0, 2'b01, 1'b1, 1'b1), "status_busy");
    reg_read(A_IRQ_STAT, 32'h4, "irq_timeout");
    check("irq_o_timeout", 64'(irq_o), 64'd1);
    wr_ready_i[0] = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("timeout_drained", 64'(wr_valid_o[0]), 64'd0);
    reg_write(A_IRQ_STAT, 32'h4, "irq_clr4b");

    // Read stream: valid arrives after 5 stalled cycles
    blk = {$urandom, $urandom};
    rd_data_i = blk;
    rd_valid_i = 1'b0;
    fork
      apb_xfer(1'b0, A_RD, 32'd0, rdv, ev, wv, pv);
      begin
        @(posedge clk); @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 rd_valid_i = 1'b1;
      end
    join
    check("rd_w0_waits", 64'(wv), 64'd5);
    check("rd_w0_data", 64'(rdv), 64'(blk[63:32]));
    check("rd_w0_nopop", 64'(pv), 64'd0);
    check("rd_w0_err", 64'(ev), 64'd0);
    apb_xfer(1'b0, A_RD + 10'd4, 32'd0, rdv, ev, wv, pv);
    check("rd_w1_waits", 64'(wv), 64'd0);
    check("rd_w1_data", 64'(rdv), 64'(blk[31:0]));
    check("rd_w1_pop", 64'(pv), 64'd1);
    check("rd_pop_once", 64'(rd_ready_o), 64'd0);
    rd_valid_i = 1'b0;

    // Random stream writes with intermittent back-pressure
    for (int i = 0; i < 12; i++) begin
      s = $urandom_range(0, 1);
      blk = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        wr_ready_i[s] = 1'b0;
        fork
          begin
            automatic int ss = s;
            automatic int kk = $urandom_range(1, 40);
            repeat (kk) @(posedge clk);
            #1 wr_ready_i[ss] = 1'b1;
          end
        join_none
      end
      push_block(s, blk);
    end

    // Random read-stream blocks with random word order
    seen = 2'b00;
    for (int i = 0; i < 6; i++) begin
      blk = {$urandom, $urandom};
      rd_data_i = blk;
      rd_valid_i = 1'b1;
      for (int j = 0; j < 20; j++) begin
        ww = $urandom_range(0, 1);
        apb_xfer(1'b0, A_RD + 10'(4 * ww), 32'd0, rdv, ev, wv, pv);
        check("rnd_rd_data", 64'(rdv), (ww == 0) ? 64'(blk[63:32]) : 64'(blk[31:0]));
        exp_pop = (ww == 1) && seen[0];
        seen[ww] = 1'b1;
        check("rnd_rd_pop", 64'(pv), 64'(exp_pop));
        if (exp_pop) begin
          seen = 2'b00;
          break;
        end
      end
      rd_valid_i = 1'b0;
    end

    // Drain and final scoreboard state
    wr_ready_i = 2'b11;
    repeat (60) @(posedge clk);
    #1;
    check("q0_empty", 64'(exp_q0.size()), 64'd0);
    check("q1_empty", 64'(exp_q1.size()), 64'd0);
    check("final_wr_valid", 64'(wr_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
